// File: rtl/data_bus_resp.sv
`timescale 1ns/1ps
// Data-memory responder: word RAM, UART transmitter with TX FIFO, and GPIO registers,
// decoded from addr[31:28]. Read data is combinational, writes commit at the clock edge.
module data_bus_resp #(
  parameter int RAM_WORDS  = 1024,
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 16,
  parameter int GPIO_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wmem_en_i,
  input  logic              rmem_en_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       wmem_data_i,
  output logic [31:0]       rmem_data_o,
  output logic              uart_tx_o,
  input  logic [GPIO_W-1:0] gpio_in_i,
  output logic [GPIO_W-1:0] gpio_out_o
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // ---------------- address decode ----------------
  logic [3:0]    region;
  logic [1:0]    reg_sel;
  logic          sel_ram, sel_uart, sel_gpio;
  logic [AW-1:0] ram_idx;
  logic          unused_addr;

  assign region      = mem_addr_i[31:28];
  assign reg_sel     = mem_addr_i[3:2];
  assign sel_ram     = (region == 4'h0);
  assign sel_uart    = (region == 4'h1);
  assign sel_gpio    = (region == 4'h2);
  assign ram_idx     = mem_addr_i[AW+1:2];
  assign unused_addr = ^{mem_addr_i[27:4], mem_addr_i[1:0]};

  // ---------------- data RAM (not reset) ----------------
  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (wmem_en_i && sel_ram) ram[ram_idx] <= wmem_data_i;
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          push_req, push_ok, drop, pop;
  logic          status_rd, overflow;

  assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign push_req   = wmem_en_i && sel_uart && (reg_sel == 2'd0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;
  assign status_rd  = rmem_en_i && sel_uart && (reg_sel == 2'd1);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= wmem_data_i[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop)           overflow <= 1'b1;
      else if (status_rd) overflow <= 1'b0;
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t     state, state_d;
  logic [BW-1:0] baud, baud_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shift, shift_d;
  logic          tx_q, tx_d;
  logic          busy;

  assign busy      = (state != IDLE);
  assign uart_tx_o = tx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d   = state;
    baud_d    = baud;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr];
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud == BAUD_LAST) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          baud_d = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_d = STOP;
          else                 bit_idx_d = bit_idx + 1'b1;
        end else begin
          baud_d = baud + 1'b1;
        end
      end
      STOP: begin
        if (baud == BAUD_LAST) begin
          baud_d = '0;
          // Chain straight into the next start bit when more bytes are queued.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_mem[rd_ptr];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // The line level is registered from the next state so uart_tx_o is a clean flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // ---------------- GPIO ----------------
  logic [GPIO_W-1:0] gpio_s1, gpio_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_out_o <= '0;
      gpio_s1    <= '0;
      gpio_s2    <= '0;
    end else begin
      gpio_s1 <= gpio_in_i;
      gpio_s2 <= gpio_s1;
      if (wmem_en_i && sel_gpio && (reg_sel == 2'd0)) gpio_out_o <= wmem_data_i[GPIO_W-1:0];
    end
  end

  // ---------------- read mux ----------------
  logic [31:0] status_word;

  assign status_word = {16'h0, 8'(fifo_count), 4'h0, overflow, fifo_empty, fifo_full, busy};

  always_comb begin
    rmem_data_o = 32'h0;
    if (rmem_en_i) begin
      case (region)
        4'h0: rmem_data_o = ram[ram_idx];
        4'h1: if (reg_sel == 2'd1) rmem_data_o = status_word;
        4'h2: begin
          if (reg_sel == 2'd0)      rmem_data_o = 32'(gpio_out_o);
          else if (reg_sel == 2'd1) rmem_data_o = 32'(gpio_s2);
        end
        default: rmem_data_o = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_resp.sv
`timescale 1ns/1ps
// Directed bench for data_bus_resp: bus vector table plus hand-timed UART, GPIO and reset sequences.
module tb_data_bus_resp;

  localparam int GPIO_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              wmem_en, rmem_en;
  logic [31:0]       mem_addr, wmem_data, rmem_data;
  logic              uart_tx;
  logic [GPIO_W-1:0] gpio_in, gpio_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  data_bus_resp #(.RAM_WORDS(64), .CLK_DIV(4), .FIFO_DEPTH(4), .GPIO_W(GPIO_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .wmem_en_i   (wmem_en),
    .rmem_en_i   (rmem_en),
    .mem_addr_i  (mem_addr),
    .wmem_data_i (wmem_data),
    .rmem_data_o (rmem_data),
    .uart_tx_o   (uart_tx),
    .gpio_in_i   (gpio_in),
    .gpio_out_o  (gpio_out)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    wmem_en   = we;
    rmem_en   = re;
    mem_addr  = a;
    wmem_data = d;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // Checks one 40-cycle frame (CLK_DIV=4) on consecutive negedges; caller sits just after the pop edge.
  task automatic monitor_frame(input logic [7:0] b, input logic check_busy);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check($sformatf("tx_%02h_bit%0d_cyc%0d", b, i / 4, i % 4), 32'(uart_tx), 32'(frame_bit(b, i / 4)));
      if (check_busy) check($sformatf("busy_%02h_cyc%0d", b, i), 32'(rmem_data[0]), 32'h1);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [15:0] exp_gpio;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [7:0] b;
    int         high_cnt;

    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         16'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 16'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 16'h0};
    vecs[3]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h1,         32'hDEAD_BEEF, 16'h0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'h1,         16'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'h2000_0000, 32'h0000_1234, 32'h0,         16'h0};
    vecs[6]  = '{1'b0, 1'b1, 32'h2000_0000, 32'h0,         32'h0000_1234, 16'h1234};
    vecs[7]  = '{1'b1, 1'b0, 32'h3000_0000, 32'hFFFF_FFFF, 32'h0,         16'h1234};
    vecs[8]  = '{1'b0, 1'b1, 32'h3000_0000, 32'h0,         32'h0,         16'h1234};
    vecs[9]  = '{1'b0, 1'b1, 32'h1000_0008, 32'h0,         32'h0,         16'h1234};
    vecs[10] = '{1'b0, 1'b1, 32'h2000_0008, 32'h0,         32'h0,         16'h1234};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0110, 32'h0,         32'h1,         16'h1234};
    vecs[12] = '{1'b0, 1'b0, 32'h2000_0000, 32'h0,         32'h0,         16'h1234};
    vecs[13] = '{1'b0, 1'b1, 32'h1000_0000, 32'h0,         32'h0,         16'h1234};

    // ---------------- reset ----------------
    rst     = 1'b1;
    gpio_in = '0;
    bus(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    bus(1'b0, 1'b1, 32'h1000_0004, 32'h0);
    @(negedge clk);
    check("reset_tx", 32'(uart_tx), 32'h1);
    check("reset_gpio_out", 32'(gpio_out), 32'h0);
    check("reset_status", rmem_data, 32'h0000_0004);

    // ---------------- bus vector table ----------------
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1 bus(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      check($sformatf("vec%0d_rdata", i), rmem_data, vecs[i].exp_rdata);
      check($sformatf("vec%0d_gpio_out", i), 32'(gpio_out), 32'(vecs[i].exp_gpio));
    end

    // ---------------- GPIO input synchronizer ----------------
    @(posedge clk);
    #1 bus(1'b0, 1'b1, 32'h2000_0004, 32'h0);
    gpio_in = 16'h00FF;
    @(negedge clk);
    check("gpio_in_edge0", rmem_data, 32'h0);
    @(negedge clk);
    check("gpio_in_edge1", rmem_data, 32'h0);
    @(negedge clk);
    check("gpio_in_edge2", rmem_data, 32'h0000_00FF);

    // ---------------- UART single byte ----------------
    @(posedge clk);
    #1 bus(1'b1, 1'b0, 32'h1000_0000, 32'h0000_00A5);
    @(posedge clk);                               // E0: push
    #1 bus(1'b0, 1'b1, 32'h1000_0004, 32'h0);
    @(negedge clk);
    check("single_pre_pop_status", rmem_data, 32'h0000_0100);
    check("single_pre_pop_tx", 32'(uart_tx), 32'h1);
    @(posedge clk);                               // E1: pop
    monitor_frame(8'hA5, 1'b1);
    @(negedge clk);
    check("single_post_tx", 32'(uart_tx), 32'h1);
    check("single_post_status", rmem_data, 32'h0000_0004);

    // ---------------- FIFO full / overflow / back-to-back ----------------
    exp_q = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    @(posedge clk);
    #1 bus(1'b1, 1'b0, 32'h1000_0000, 32'h0000_0011);
    @(posedge clk);                               // E0
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          #1 bus(1'b1, 1'b0, 32'h1000_0000, 32'(8'h12 + k));
          @(posedge clk);                         // E1..E5; 0x16 dropped at E5
        end
        #1 bus(1'b0, 1'b1, 32'h1000_0004, 32'h0);
        @(negedge clk);
        check("ovf_status_first", rmem_data, 32'h0000_040B);
        @(negedge clk);
        check("ovf_status_second", rmem_data, 32'h0000_0403);
        bus(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (34) @(posedge clk);               // E40
        #1 bus(1'b1, 1'b0, 32'h1000_0000, 32'h0000_0017);
        exp_q.push_back(8'h17);
        @(posedge clk);                           // E41: push into full FIFO alongside pop
        #1 bus(1'b0, 1'b1, 32'h1000_0004, 32'h0);
        @(negedge clk);
        check("full_push_pop_status", rmem_data, 32'h0000_0403);
        bus(1'b0, 1'b0, 32'h0, 32'h0);
      end
      begin
        @(posedge clk);                           // E1
        for (int f = 0; f < 6; f++) begin
          if (exp_q.size() == 0) begin
            check($sformatf("frame%0d_expected_available", f), 32'h0, 32'h1);
            b = 8'h00;
          end else begin
            b = exp_q.pop_front();
          end
          monitor_frame(b, 1'b0);
        end
      end
    join
    @(posedge clk);
    #1 bus(1'b0, 1'b1, 32'h1000_0004, 32'h0);
    @(negedge clk);
    check("ovf_final_status", rmem_data, 32'h0000_0004);
    check("ovf_final_tx", 32'(uart_tx), 32'h1);
    check("ovf_queue_drained", 32'(exp_q.size()), 32'h0);

    // ---------------- reset mid-frame ----------------
    @(posedge clk);
    #1 bus(1'b1, 1'b0, 32'h1000_0000, 32'h0000_005A);
    @(posedge clk);                               // E0
    #1 bus(1'b1, 1'b0, 32'h1000_0000, 32'h0000_006B);
    @(posedge clk);                               // E1: pop 0x5A, push 0x6B
    bus(1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #2 check("midframe_tx_start", 32'(uart_tx), 32'h0);
    #1 rst = 1'b1;
    #1 check("midframe_rst_tx", 32'(uart_tx), 32'h1);
    check("midframe_rst_gpio_out", 32'(gpio_out), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus(1'b0, 1'b1, 32'h1000_0004, 32'h0);
    @(negedge clk);
    check("midframe_rst_status", rmem_data, 32'h0000_0004);
    high_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b1) high_cnt++;
    end
    check("post_rst_tx_idle_cycles", 32'(high_cnt), 32'd50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_bus_resp.md
# data_bus_resp

Responder end of the core's data-memory port: accepts the core's per-cycle read/write requests (`wmem_en`, `rmem_en`, `mem_addr`, `wmem_data`) and returns `rmem_data` in the same cycle. Decodes the address into data RAM, a UART transmitter with TX FIFO, and GPIO registers. Sits outside the core, next to the instruction ROM, in the SoC top level.

## Interface

Parameters:
- RAM_WORDS, 1024: data RAM depth in 32-bit words; power of two.
- CLK_DIV, 868: clock cycles per UART bit; at least 2.
- FIFO_DEPTH, 16: UART TX FIFO entries; power of two.
- GPIO_W, 16: GPIO input and output width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wmem_en_i  in  1  write strobe from the core.
- rmem_en_i  in  1  read strobe from the core.
- mem_addr_i  in  32  byte address.
- wmem_data_i  in  32  write data; word-only.
- rmem_data_o  out  32  read data; combinational, valid in the same cycle as the request.
- uart_tx_o  out  1  serial TX line, 8N1, LSB first; idle high.
- gpio_in_i  in  GPIO_W  asynchronous external inputs.
- gpio_out_o  out  GPIO_W  output register.

## Operation

Address decode uses addr[31:28]. Address bits [1:0] are ignored, so every access is a full 32-bit word.

- **0x0 RAM.**
  - Word index is addr[log2(RAM_WORDS)+1:2]; upper bits alias.
  - Read is combinational from the array.
  - Write commits at the clock edge.
- **0x1 UART**, selected by addr[3:2]:
  - 0 TXDATA. A write pushes wdata[7:0] into the FIFO. Reads return 0.
  - 1 STATUS. Read-only. bit0 busy (FSM≠IDLE), bit1 fifo_full, bit2 fifo_empty, bit3 overflow (sticky), bits[15:8] FIFO count, all other bits 0.
- **0x2 GPIO**, selected by addr[3:2]:
  - 0 OUT. Read/write. Write loads wdata[GPIO_W-1:0].
  - 1 IN. Read-only. Returns the 2-flop-synchronized gpio_in_i, zero-extended.
- **Unmapped** region or register: reads return 0; writes are ignored.
- **rmem_en_i low:** rmem_data_o = 0.
- **wmem_en_i and rmem_en_i both high:** the write commits at the edge. Read data in that cycle reflects the pre-write state.
- **Overflow:**
  - A push while the FIFO is full is dropped and sets overflow.
  - overflow clears at the edge of any STATUS read.
  - If a drop and a STATUS read occur in the same cycle, set wins.
- **TX FSM** states IDLE, START, DATA, STOP. A baud counter runs 0..CLK_DIV-1; a bit index runs 0..7.
  - IDLE: tx=1. If the FIFO is not empty, pop into the shift register and go to START.
  - START: tx=0 for CLK_DIV cycles, then go to DATA.
  - DATA: tx=shift[0]; shift right every CLK_DIV cycles; after bit 7 go to STOP.
  - STOP: tx=1 for CLK_DIV cycles. Then, if the FIFO is not empty, pop and go to START (back-to-back frames); otherwise go to IDLE.
- **FIFO push and pop in the same cycle:** both happen and the count is unchanged. This holds even when the FIFO is full, because the pop frees the slot first and the push is not an overflow.

## Timing

- Reset values:
  - uart_tx_o = 1; gpio_out_o = 0.
  - FIFO empty, count 0; overflow 0; FSM IDLE; counters 0; synchronizer flops 0.
  - RAM contents are not reset.
- Reset asserted mid-frame: uart_tx_o goes to 1 immediately and the FIFO contents are discarded.
- uart_tx_o is driven from a flop, with no combinational path from the inputs.
- Read latency is 0 cycles for every region.
- A GPIO OUT write is visible on gpio_out_o after the same edge.
- gpio_in_i reaches the IN register 2 edges after it changes.
- TX latency, with a TXDATA push at edge E0 into an idle, empty FIFO:
  - The pop happens at E1, and uart_tx_o falls after E1.
  - The frame is exactly 10*CLK_DIV cycles, with the stop-bit end at E1+10*CLK_DIV.
- Back-to-back bytes have no idle gap between the stop bit and the next start bit.

## Test plan

- **Reset:** assert rst mid-frame -> uart_tx_o=1, gpio_out_o=0, STATUS read = 0x0000_0004.
- **RAM:** write 0xDEADBEEF to 0x0000_0010; read 0x0000_0010 and 0x0000_0013 -> 0xDEADBEEF both. Simultaneous read+write of 0x0000_0010 with new data 0x1 -> rdata 0xDEADBEEF that cycle, 0x1 after.
- **UART single byte, CLK_DIV=4:** push 0xA5 -> tx low from E1 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then high 4 cycles. STATUS.busy=1 throughout the frame.
- **UART FIFO full/overflow, FIFO_DEPTH=4:**
  - Push 6 bytes in consecutive cycles -> first pops at E1, 4 stored, 1 dropped, STATUS = 0x0000_040B (count 4, overflow, full, busy).
  - A second STATUS read -> overflow 0.
  - Transmitted bytes are exactly the first five, back-to-back.
- **GPIO:** write 0x1234 to 0x2000_0000 -> gpio_out_o=0x1234, read back 0x0000_1234. Drive gpio_in_i=0x00FF -> IN read = 0x00FF from the 2nd edge on, 0 before.
- **Unmapped:** write 0x3000_0000 / read 0x3000_0000 and 0x1000_0008 -> 0, no state change.
